// File: rtl/eth_frame_swap.sv
// eth_frame_swap: loopback header rewriter (MAC swap, IPv4 TCP/UDP classification); ETH_FRAME_SWAP_L3L4_EN adds IP/port swap
module eth_frame_swap #(
  parameter int C_CNT_WIDTH = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic [7:0] s_axis_tdata,
  input  logic       s_axis_tuser,
  input  logic       s_axis_tlast,
  input  logic       s_axis_tvalid,
  output logic [7:0] m_axis_tdata,
  output logic [1:0] m_axis_tuser,
  output logic       m_axis_tlast,
  output logic       m_axis_tvalid,
  output logic       drop_pulse
);
  typedef enum logic [2:0] {IDLE, FILL, STREAM, FLUSH, DROP} state_t;
  localparam logic [C_CNT_WIDTH-1:0] CNT_MAX = '1;
  state_t state, state_n;
  logic [7:0] d [12];
  logic [7:0] stash [6];
  logic [C_CNT_WIDTH-1:0] cnt;
  logic [5:0] pos;
  logic [3:0] rem, base;
  logic short_f, en_r, err, cls, drop_pend;
  logic acc, emit, sw, cls_ok, dp_n, hit;
  logic [7:0] mac, obyte;

  function automatic logic [7:0] pick(input logic [7:0] v [12], input logic [4:0] i);
    return (i < 5'd12) ? v[i[3:0]] : 8'h00;
  endfunction

  // frame sequencing: fill the delay line, stream, drain, discard overlapping frames
  always_comb begin
    state_n = state;
    acc = s_axis_tvalid && (state == IDLE || state == FILL || state == STREAM);
    dp_n = (state == FLUSH && s_axis_tvalid) ? !s_axis_tlast : drop_pend;
    hit = state == FLUSH && s_axis_tvalid && !drop_pend;
    case (state)
      IDLE:    if (s_axis_tvalid) state_n = s_axis_tlast ? FLUSH : FILL;
      FILL:    if (s_axis_tvalid) state_n = s_axis_tlast ? FLUSH : (cnt == C_CNT_WIDTH'(11) ? STREAM : FILL);
      STREAM:  if (s_axis_tvalid && s_axis_tlast) state_n = FLUSH;
      FLUSH:   if (rem == 4'd1) state_n = dp_n ? DROP : IDLE;
      DROP:    if (s_axis_tvalid && s_axis_tlast) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  // output byte select; base points at the oldest unsent byte while draining
  always_comb begin
    emit = (state == STREAM && s_axis_tvalid) || state == FLUSH;
    base = (state == FLUSH) ? 4'd12 - rem : 4'd0;
    sw = en_r && !short_f;
    cls_ok = cls && cnt >= C_CNT_WIDTH'(38);
    mac = (sw && pos < 6'd6) ? pick(d, 5'(base) + 5'd6)
        : (sw && pos < 6'd12) ? stash[3'(pos - 6'd6)]
        : d[base];
`ifdef ETH_FRAME_SWAP_L3L4_EN
    obyte = !(sw && cls_ok) ? mac
          : (pos >= 6'd26 && pos < 6'd30) ? pick(d, 5'(base) + 5'd4)
          : (pos >= 6'd30 && pos < 6'd34) ? stash[3'(pos - 6'd30)]
          : (pos >= 6'd34 && pos < 6'd36) ? pick(d, 5'(base) + 5'd2)
          : (pos >= 6'd36 && pos < 6'd38) ? stash[3'(pos - 6'd36)]
          : mac;
`else
    obyte = mac;
`endif
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else state <= state_n;
  end

  // delay line, stash, frame bookkeeping and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 12; i++) d[i] <= 8'h00;
      for (int i = 0; i < 6; i++) stash[i] <= 8'h00;
      cnt <= '0;
      pos <= '0;
      rem <= '0;
      short_f <= 1'b0;
      en_r <= 1'b0;
      err <= 1'b0;
      cls <= 1'b0;
      drop_pend <= 1'b0;
      m_axis_tdata <= 8'h00;
      m_axis_tuser <= 2'b00;
      m_axis_tlast <= 1'b0;
      m_axis_tvalid <= 1'b0;
      drop_pulse <= 1'b0;
    end else begin
      m_axis_tvalid <= emit;
      m_axis_tdata <= emit ? obyte : 8'h00;
      m_axis_tlast <= state == FLUSH && rem == 4'd1;
      m_axis_tuser <= emit ? {cls_ok, err | (short_f && state == FLUSH && rem == 4'd1)} : 2'b00;
      drop_pulse <= hit;
      if (acc) begin
        for (int i = 0; i < 11; i++) d[i] <= d[i + 1];
        d[11] <= s_axis_tdata;
        cnt <= (state == IDLE) ? C_CNT_WIDTH'(1) : (cnt == CNT_MAX) ? cnt : cnt + C_CNT_WIDTH'(1);
        err <= (state != IDLE && err) || s_axis_tuser;
      end
      if (state == IDLE && s_axis_tvalid) begin
        en_r <= enable;
        cls <= 1'b0;
        pos <= '0;
        short_f <= s_axis_tlast;
        rem <= 4'd1;
        drop_pend <= 1'b0;
      end
      if (state == FILL && s_axis_tvalid && s_axis_tlast) begin
        short_f <= cnt != C_CNT_WIDTH'(11);
        rem <= 4'(cnt) + 4'd1;
      end
      if (state == STREAM && s_axis_tvalid && s_axis_tlast) rem <= 4'd12;
      if (state == FLUSH) begin
        rem <= rem - 4'd1;
        drop_pend <= dp_n;
      end
      if (emit) begin
        pos <= (pos == 6'd63) ? pos : pos + 6'd1;
        if (pos < 6'd6) stash[3'(pos)] <= d[base];
        if (pos >= 6'd26 && pos < 6'd30) stash[3'(pos - 6'd26)] <= d[base];
        if (pos == 6'd34 || pos == 6'd35) stash[3'(pos - 6'd34)] <= d[base];
        if (state == STREAM && pos == 6'd12)
          cls <= en_r && d[0] == 8'h08 && d[1] == 8'h00 && d[2] == 8'h45 && (d[8] & 8'h3f) == 8'h00
                 && d[9] == 8'h00 && (d[11] == 8'd6 || d[11] == 8'd17);
      end
    end
  end
endmodule

// File: tb/tb_eth_frame_swap.sv
// tb_eth_frame_swap: randomized scoreboard bench for eth_frame_swap against a frame-level reference model
module tb_eth_frame_swap;
  logic clk = 1'b0, rst_n = 1'b0, enable = 1'b0;
  logic [7:0] s_axis_tdata = 8'h00;
  logic s_axis_tuser = 1'b0, s_axis_tlast = 1'b0, s_axis_tvalid = 1'b0;
  logic [7:0] m_axis_tdata;
  logic [1:0] m_axis_tuser;
  logic m_axis_tlast, m_axis_tvalid, drop_pulse;

  eth_frame_swap dut (
    .clk(clk), .rst_n(rst_n), .enable(enable),
    .s_axis_tdata(s_axis_tdata), .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast), .s_axis_tvalid(s_axis_tvalid),
    .m_axis_tdata(m_axis_tdata), .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast), .m_axis_tvalid(m_axis_tvalid),
    .drop_pulse(drop_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {logic [7:0] d; logic last; int err_req; logic cls; int idx;} exp_t;
  exp_t q[$];
  exp_t cur;
  logic [7:0] fr[$];
  bit fe[$];
  int checks = 0, errors = 0, cyc = 0, t0 = 0, out_cyc = -1, drops_seen = 0, drops_exp = 0;
  bit quiet = 1'b0, lat_arm = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // monitor: pops the scoreboard for every output beat
  always @(negedge clk) if (rst_n) begin
    if (drop_pulse) drops_seen++;
    if (m_axis_tvalid) begin
      if (lat_arm) begin
        out_cyc = cyc;
        lat_arm = 1'b0;
      end
      if (quiet) chk("no_tlast_mid_reset", m_axis_tlast, 1'b0);
      else if (q.size() == 0) chk("unexpected_beat", 1, 0);
      else begin
        cur = q.pop_front();
        chk($sformatf("data[%0d]", cur.idx), m_axis_tdata, cur.d);
        chk($sformatf("tlast[%0d]", cur.idx), m_axis_tlast, cur.last);
        if (cur.err_req != 2) chk($sformatf("tuser0[%0d]", cur.idx), m_axis_tuser[0], cur.err_req[0]);
        if (cur.last) chk("tuser1_on_tlast", m_axis_tuser[1], cur.cls);
      end
    end
  end

  task automatic rand_frame(input int n);
    fr.delete();
    fe.delete();
    for (int i = 0; i < n; i++) begin
      fr.push_back(8'($urandom));
      fe.push_back(1'b0);
    end
  endtask

  task automatic put(input int i, input logic [7:0] v);
    if (i < fr.size()) fr[i] = v;
  endtask

  task automatic ip_frame(input int n, input logic [7:0] proto, input logic [7:0] b21);
    logic [15:0] tl;
    rand_frame(n);
    tl = 16'(n - 14);
    put(12, 8'h08); put(13, 8'h00); put(14, 8'h45); put(15, 8'h00);
    put(16, tl[15:8]); put(17, tl[7:0]); put(20, 8'h40); put(21, b21); put(22, 8'h40); put(23, proto);
    put(26, 8'd10); put(27, 8'd0); put(28, 8'd0); put(29, 8'd1);
    put(30, 8'd10); put(31, 8'd0); put(32, 8'd0); put(33, 8'd2);
    put(34, 8'h03); put(35, 8'he8); put(36, 8'h07); put(37, 8'hd0);
  endtask

  // reference: whole-frame rewrite rules applied to the byte list
  task automatic expect_frame(input bit en);
    logic [7:0] o[$];
    int n, fe1;
    bit sh, c;
    exp_t e;
    n = fr.size();
    o = fr;
    sh = n < 12;
    c = 1'b0;
    fe1 = -1;
    if (!sh && en) begin
      for (int i = 0; i < 6; i++) begin
        o[i] = fr[i + 6];
        o[i + 6] = fr[i];
      end
      c = n >= 38 && fr[12] == 8'h08 && fr[13] == 8'h00 && fr[14] == 8'h45 && (fr[20] & 8'h3f) == 8'h00
          && fr[21] == 8'h00 && (fr[23] == 8'd6 || fr[23] == 8'd17);
    end
`ifdef ETH_FRAME_SWAP_L3L4_EN
    if (c) begin
      for (int i = 0; i < 4; i++) begin
        o[26 + i] = fr[30 + i];
        o[30 + i] = fr[26 + i];
      end
      for (int i = 0; i < 2; i++) begin
        o[34 + i] = fr[36 + i];
        o[36 + i] = fr[34 + i];
      end
    end
`endif
    for (int i = n - 1; i >= 0; i--) if (fe[i]) fe1 = i;
    for (int k = 0; k < n; k++) begin
      e.d = o[k];
      e.last = k == n - 1;
      e.err_req = (fe1 < 0) ? 0 : (k >= fe1) ? 1 : 2;
      if (sh && k == n - 1) e.err_req = 1;
      e.cls = c;
      e.idx = k;
      q.push_back(e);
    end
  endtask

  task automatic drive(input bit en, input int gap);
    for (int i = 0; i < fr.size(); i++) begin
      if (gap > 0) while ($urandom_range(0, 99) < gap) begin
        s_axis_tvalid = 1'b0;
        @(posedge clk); #1;
      end
      if (i == 0) begin
        enable = en;
        t0 = cyc;
      end else enable = 1'($urandom);
      s_axis_tvalid = 1'b1;
      s_axis_tdata = fr[i];
      s_axis_tuser = fe[i];
      s_axis_tlast = (i == fr.size() - 1);
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    s_axis_tlast = 1'b0;
    s_axis_tuser = 1'b0;
  endtask

  task automatic frame(input bit en, input int gap);
    expect_frame(en);
    drive(en, gap);
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("rst_tvalid", m_axis_tvalid, 1'b0);
    chk("rst_tlast", m_axis_tlast, 1'b0);
    chk("rst_tuser", m_axis_tuser, 2'b00);
    chk("rst_tdata", m_axis_tdata, 8'h00);
    chk("rst_drop", drop_pulse, 1'b0);
    rst_n = 1'b1;
    idle(2);
    rand_frame(60);
    for (int i = 0; i < 6; i++) begin
      fr[i] = 8'(i + 1);
      fr[i + 6] = 8'(8'h11 + i);
    end
    lat_arm = 1'b1;
    frame(1'b1, 0);
    idle(25);
    chk("first_out_latency", out_cyc - t0, 13);
    ip_frame(64, 8'd17, 8'h00); frame(1'b1, 0); idle(25);
    ip_frame(64, 8'd17, 8'h01); frame(1'b1, 10); idle(25);
    ip_frame(64, 8'd1, 8'h00); frame(1'b1, 0); idle(25);
    ip_frame(64, 8'd6, 8'h00); frame(1'b0, 0); idle(25);
    ip_frame(38, 8'd6, 8'h00); frame(1'b1, 10); idle(25);
    ip_frame(37, 8'd6, 8'h00); frame(1'b1, 0); idle(25);
    rand_frame(8); frame(1'b1, 0); idle(25);
    rand_frame(1); frame(1'b1, 0); idle(25);
    rand_frame(12); frame(1'b1, 0); idle(25);
    rand_frame(13); frame(1'b1, 20); idle(25);
    rand_frame(60); fe[30] = 1'b1; frame(1'b1, 0); idle(25);
    rand_frame(60); frame(1'b1, 0); idle(2);
    rand_frame(30); drive(1'b1, 0); drops_exp++; idle(25);
    ip_frame(50, 8'd17, 8'h00); frame(1'b1, 0); idle(2);
    rand_frame(4); drive(1'b1, 0); drops_exp++; idle(25);
    rand_frame(40); frame(1'b1, 0); idle(25);
    quiet = 1'b1;
    rand_frame(40);
    enable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      s_axis_tvalid = 1'b1;
      s_axis_tdata = fr[i];
      @(posedge clk); #1;
    end
    s_axis_tvalid = 1'b0;
    rst_n = 1'b0;
    #2;
    chk("midrst_tvalid", m_axis_tvalid, 1'b0);
    chk("midrst_tlast", m_axis_tlast, 1'b0);
    chk("midrst_tdata", m_axis_tdata, 8'h00);
    chk("midrst_drop", drop_pulse, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    quiet = 1'b0;
    idle(3);
    ip_frame(64, 8'd6, 8'h00); frame(1'b1, 0); idle(25);
    for (int f = 0; f < 40; f++) begin
      int n;
      n = $urandom_range(1, 90);
      if (n >= 38 && $urandom_range(0, 1) == 1) begin
        case ($urandom_range(0, 3))
          0: ip_frame(n, 8'd6, 8'h00);
          1: ip_frame(n, 8'd17, 8'h00);
          2: ip_frame(n, 8'd1, 8'h00);
          default: ip_frame(n, 8'd17, 8'($urandom_range(0, 2)));
        endcase
      end else rand_frame(n);
      if ($urandom_range(0, 4) == 0) fe[$urandom_range(0, n - 1)] = 1'b1;
      frame(1'($urandom_range(0, 3) != 0), $urandom_range(0, 30));
      idle(20 + $urandom_range(0, 5));
    end
    for (int i = 0; i < 500 && q.size() > 0; i++) @(posedge clk);
    idle(2);
    chk("scoreboard_drained", q.size(), 0);
    chk("drop_pulse_count", drops_seen, drops_exp);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
